fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 8, program-counter and instruction-memory address width.
REQ-002 Parameter INSTRUCTION_WIDTH, default 16, instruction word width.
REQ-003 Parameter RESET_PC, default 0, fetch address after reset.
REQ-004 Parameter STACK_DEPTH, default 4, return-stack entries (power of two).
REQ-005 Port clock  in  1  single clock; all state on rising edge.
REQ-006 Port reset  in  1  asynchronous, active-high.
REQ-007 Port pc  out  PC_WIDTH  address to instruction memory; memory returns instruction_in combinationally in the same cycle.
REQ-008 Port instruction_in  in  INSTRUCTION_WIDTH  word read at pc.
REQ-009 Port ir  out  INSTRUCTION_WIDTH  registered instruction for decode.
REQ-010 Port ir_pc  out  PC_WIDTH  address that ir was fetched from.
REQ-011 Port ir_valid  out  1  ir holds a live instruction.
REQ-012 Port ir_ready  in  1  decode accepts ir this cycle.
REQ-013 Port redirect  in  1  taken branch/jump/call from execute.
REQ-014 Port redirect_target  in  PC_WIDTH  new fetch address.
REQ-015 Port call  in  1  qualifies redirect as subroutine call.
REQ-016 Port ret  in  1  return from subroutine.
REQ-017 Port halt  in  1  stop fetching.
REQ-018 Port stack_error  out  1  sticky return-stack over/underflow flag.

Function
REQ-019 States: IDLE, FETCH, HALTED; IDLE -> FETCH unconditionally after one cycle; no load occurs in IDLE.
REQ-020 FETCH, load condition (!ir_valid || ir_ready): ir<=instruction_in, ir_pc<=pc, ir_valid<=1, pc<=pc+1; latency pc-to-ir one cycle.
REQ-021 FETCH, ir_valid && !ir_ready: pc, ir, ir_pc, ir_valid all hold.
REQ-022 pc+1 wraps modulo 2^PC_WIDTH (all-ones -> 0), no flag.
REQ-023 redirect (any state, stall or not): pc<=redirect_target, ir_valid<=0 (flush), next state FETCH.
REQ-024 Priority, highest first: reset, redirect, ret, halt, normal load.
REQ-025 halt in FETCH without redirect/ret: next state HALTED; no further loads; pending ir stays until accepted, then ir_valid<=0.
REQ-026 HALTED exits only via redirect (to FETCH) or reset; ret in HALTED is ignored.
REQ-027 redirect && call: push ir_pc+1 (wrapping) onto return stack, then REQ-023.
REQ-028 ret without redirect: pc<=top of stack, pop, ir_valid<=0.
REQ-029 Push when full: push dropped, stack_error<=1, redirect still taken.
REQ-030 Pop when empty: pc<=RESET_PC, stack_error<=1, ir_valid<=0.
REQ-031 redirect && call && ret together: call wins, ret ignored.

Reset
REQ-032 On reset assertion, asynchronously: pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, state=IDLE, stack empty, stack_error=0.
REQ-033 Reset asserted mid-stall or mid-call discards all in-flight state; first ir after release is from RESET_PC.

Configuration
REQ-034 Macro RETURN_STACK_EN defined: return stack, call/ret handling and stack_error per REQ-027..031.
REQ-035 Macro RETURN_STACK_EN undefined: call is a plain redirect, ret ignored, stack_error tied 0, no stack storage; all ports remain.

Structure
REQ-036 PC_WIDTH, INSTRUCTION_WIDTH defaults and the state enum (IDLE, FETCH, HALTED) live in the shared parameters package.
REQ-037 Return stack is sub-module return_stack (push, pop, data_in, top, full, empty), instantiated only under RETURN_STACK_EN.

Verification
REQ-038 Reset release, ir_ready=1, memory[n]=n+0x100 -> ir_valid rises on 2nd edge, ir=0x0100 ir_pc=0, then 0x0101 ir_pc=1 each cycle.
REQ-039 ir_ready=0 for 3 cycles at ir_pc=5 -> ir, ir_pc, pc frozen at 5, 5, 6; release -> ir_pc=6 next cycle.
REQ-040 pc=0xFF, ir_ready=1 -> next ir_pc=0xFF, following ir_pc=0x00.
REQ-041 redirect target 0x40 during stall -> ir_valid=0 next cycle, then ir_pc=0x40.
REQ-042 RETURN_STACK_EN: call at ir_pc=0x10 to 0x80, ret -> fetch resumes at 0x11; 5 nested calls with depth 4 -> stack_error=1; ret on empty -> pc=RESET_PC.
REQ-043 halt at ir_pc=0x20 -> no new loads, ir_valid drops after accept; redirect 0x30 -> ir_pc=0x30 fetched.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared defaults and state encoding for the fetch unit.
package fetch_unit_pkg;

    localparam int PC_WIDTH_DEFAULT          = 8;
    localparam int INSTRUCTION_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_return_stack.sv
// LIFO of return addresses. Push onto a full stack or pop from an empty one is ignored.
module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_MAX = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] COUNT_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] entries [DEPTH];
    logic [PTR_W:0]   count;

    assign full  = (count == COUNT_MAX);
    assign empty = (count == '0);
    assign top   = entries[PTR_W'(count - COUNT_ONE)];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + COUNT_ONE;
        end else if (pop && !empty) begin
            count <= count - COUNT_ONE;
        end
    end

    // Entry storage needs no reset; the count alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (push && !full) begin
            entries[PTR_W'(count)] <= data_in;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with stall, redirect and halt; optional return stack under RETURN_STACK_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH          = PC_WIDTH_DEFAULT,
    parameter int                  INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT,
    parameter logic [PC_WIDTH-1:0] RESET_PC          = '0,
    parameter int                  STACK_DEPTH       = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic [PC_WIDTH-1:0]          pc,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
    output logic [INSTRUCTION_WIDTH-1:0] ir,
    output logic [PC_WIDTH-1:0]          ir_pc,
    output logic                         ir_valid,
    input  logic                         ir_ready,
    input  logic                         redirect,
    input  logic [PC_WIDTH-1:0]          redirect_target,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         halt,
    output logic                         stack_error
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    fetch_state_t                 state, state_next;
    logic [PC_WIDTH-1:0]          pc_next, ir_pc_next;
    logic [INSTRUCTION_WIDTH-1:0] ir_next;
    logic                         valid_next, error_next;

`ifdef RETURN_STACK_EN
    logic                stack_push, stack_pop, stack_full, stack_empty;
    logic [PC_WIDTH-1:0] stack_top;

    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clock   (clock),
        .reset   (reset),
        .push    (stack_push),
        .pop     (stack_pop),
        .data_in (ir_pc + PC_ONE),
        .top     (stack_top),
        .full    (stack_full),
        .empty   (stack_empty)
    );
`else
    logic unused_stack_inputs;
    assign unused_stack_inputs = call ^ ret ^ (STACK_DEPTH > 0);
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        ir_next    = ir;
        ir_pc_next = ir_pc;
        valid_next = ir_valid;
        error_next = stack_error;
`ifdef RETURN_STACK_EN
        stack_push = 1'b0;
        stack_pop  = 1'b0;
`endif
        if (redirect) begin
            pc_next    = redirect_target;
            valid_next = 1'b0;
            state_next = FETCH;
`ifdef RETURN_STACK_EN
            // A call overflowing the stack still jumps; only the return address is lost.
            if (call) begin
                if (stack_full) error_next = 1'b1;
                else            stack_push = 1'b1;
            end
`endif
        end
`ifdef RETURN_STACK_EN
        else if (ret && state != HALTED) begin
            valid_next = 1'b0;
            state_next = FETCH;
            if (stack_empty) begin
                pc_next    = RESET_PC;
                error_next = 1'b1;
            end else begin
                pc_next   = stack_top;
                stack_pop = 1'b1;
            end
        end
`endif
        else begin
            unique case (state)
                IDLE: state_next = FETCH;
                FETCH: begin
                    if (halt) begin
                        // Stop loading but let decode drain the instruction already in ir.
                        state_next = HALTED;
                        if (ir_ready) valid_next = 1'b0;
                    end else if (!ir_valid || ir_ready) begin
                        ir_next    = instruction_in;
                        ir_pc_next = pc;
                        valid_next = 1'b1;
                        pc_next    = pc + PC_ONE;
                    end
                end
                HALTED: begin
                    if (ir_ready) valid_next = 1'b0;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            ir          <= '0;
            ir_pc       <= '0;
            ir_valid    <= 1'b0;
            stack_error <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            ir          <= ir_next;
            ir_pc       <= ir_pc_next;
            ir_valid    <= valid_next;
            stack_error <= error_next;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit; stack scenarios run when RETURN_STACK_EN is defined.
module tb_fetch_unit;

    localparam int PW = 8;
    localparam int IW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [PW-1:0] pc;
    logic [IW-1:0] instruction_in;
    logic [IW-1:0] ir;
    logic [PW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready = 1'b0;
    logic          redirect = 1'b0;
    logic [PW-1:0] redirect_target = '0;
    logic          call = 1'b0;
    logic          ret = 1'b0;
    logic          halt = 1'b0;
    logic          stack_error;

    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] expected_q[$];
    logic [PW-1:0] exp_pc;

    always #5 clock = ~clock;

    // Instruction memory: word at address n is n + 0x100.
    assign instruction_in = {8'h00, pc} + 16'h0100;

    fetch_unit #(
        .PC_WIDTH          (PW),
        .INSTRUCTION_WIDTH (IW),
        .RESET_PC          (8'h00),
        .STACK_DEPTH       (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pc              (pc),
        .instruction_in  (instruction_in),
        .ir              (ir),
        .ir_pc           (ir_pc),
        .ir_valid        (ir_valid),
        .ir_ready        (ir_ready),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .call            (call),
        .ret             (ret),
        .halt            (halt),
        .stack_error     (stack_error)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Monitor: every instruction handed to decode must match the head of the queue.
    always @(negedge clock) begin
        if (!reset && ir_valid && ir_ready) begin
            if (expected_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_accept actual=%0h required=none", ir_pc);
            end else begin
                exp_pc = expected_q.pop_front();
                check("accept_ir_pc", ir_pc, exp_pc);
                check("accept_ir", ir, {8'h00, exp_pc} + 16'h0100);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic expect_range(input int first, input int count);
        for (int i = 0; i < count; i++) expected_q.push_back(PW'(first + i));
    endtask

    task automatic run_until(input logic [PW-1:0] target);
        int n = 0;
        while (!(ir_valid && ir_pc == target) && n < 300) begin
            step();
            n++;
        end
        check("run_until_reached", (n < 300), 1);
    endtask

    task automatic do_redirect(input logic [PW-1:0] target, input logic is_call);
        redirect        = 1'b1;
        redirect_target = target;
        call            = is_call;
        step();
        redirect = 1'b0;
        call     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        ir_ready = 1'b1;
        #1 reset = 1'b1;
        #2;
        check("reset_pc", pc, 8'h00);
        check("reset_ir", ir, 16'h0000);
        check("reset_ir_pc", ir_pc, 8'h00);
        check("reset_ir_valid", ir_valid, 1'b0);
        check("reset_stack_error", stack_error, 1'b0);
        step();
        reset = 1'b0;

        // Sequential fetch; ir_valid first rises on the second edge after release
        expect_range(0, 5);
        step();
        check("idle_no_load", ir_valid, 1'b0);
        step();
        check("first_ir_valid", ir_valid, 1'b1);
        check("first_ir_pc", ir_pc, 8'h00);
        check("first_ir", ir, 16'h0100);
        run_until(8'h05);
        ir_ready = 1'b0;

        // Stall for three cycles at ir_pc=5
        repeat (3) begin
            check("stall_ir_pc", ir_pc, 8'h05);
            check("stall_ir", ir, 16'h0105);
            check("stall_pc", pc, 8'h06);
            step();
        end
        expect_range(5, 3);
        ir_ready = 1'b1;
        step();
        check("release_ir_pc", ir_pc, 8'h06);
        run_until(8'h08);
        ir_ready = 1'b0;

        // Redirect while stalled flushes, then fetches the target
        do_redirect(8'h40, 1'b0);
        check("redirect_flush", ir_valid, 1'b0);
        check("redirect_pc", pc, 8'h40);
        step();
        check("redirect_ir_valid", ir_valid, 1'b1);
        check("redirect_ir_pc", ir_pc, 8'h40);

        // Wrap from 0xFF to 0x00
        expected_q.push_back(8'h40);
        expected_q.push_back(8'hFE);
        expected_q.push_back(8'hFF);
        expected_q.push_back(8'h00);
        ir_ready = 1'b1;
        do_redirect(8'hFE, 1'b0);
        run_until(8'h01);
        ir_ready = 1'b0;
        check("wrap_pc", pc, 8'h02);

        // Halt at 0x20: drain, stop, then restart via redirect
        do_redirect(8'h1E, 1'b0);
        expect_range(8'h1E, 3);
        ir_ready = 1'b1;
        run_until(8'h20);
        halt = 1'b1;
        step();
        halt = 1'b0;
        check("halt_drain_valid", ir_valid, 1'b0);
        check("halt_pc", pc, 8'h21);
        step();
        step();
        check("halted_valid", ir_valid, 1'b0);
        check("halted_pc", pc, 8'h21);
        check("halted_ir_pc", ir_pc, 8'h20);
        ret = 1'b1;
        step();
        ret = 1'b0;
        check("halted_ret_ignored_pc", pc, 8'h21);
        check("halted_ret_ignored_valid", ir_valid, 1'b0);
        expected_q.push_back(8'h30);
        do_redirect(8'h30, 1'b0);
        run_until(8'h31);
        ir_ready = 1'b0;

`ifdef RETURN_STACK_EN
        // Call at 0x10 to 0x80, return resumes at 0x11
        do_redirect(8'h0E, 1'b0);
        expect_range(8'h0E, 2);
        ir_ready = 1'b1;
        run_until(8'h10);
        ir_ready = 1'b0;
        do_redirect(8'h80, 1'b1);
        expected_q.push_back(8'h80);
        ir_ready = 1'b1;
        run_until(8'h81);
        ir_ready = 1'b0;
        ret = 1'b1;
        step();
        ret = 1'b0;
        check("ret_pc", pc, 8'h11);
        check("ret_flush", ir_valid, 1'b0);
        expected_q.push_back(8'h11);
        ir_ready = 1'b1;
        run_until(8'h12);
        ir_ready = 1'b0;
        check("no_stack_error_yet", stack_error, 1'b0);

        // Five nested calls overflow a four-entry stack
        for (int i = 0; i < 5; i++) begin
            do_redirect(PW'(8'h90 + i), 1'b1);
            if (i == 3) check("stack_full_no_error", stack_error, 1'b0);
        end
        check("overflow_error", stack_error, 1'b1);
        check("overflow_still_redirects", pc, 8'h94);
        expected_q.push_back(8'h94);
        ir_ready = 1'b1;
        run_until(8'h95);
        ir_ready = 1'b0;

        // Four returns unwind, the fifth underflows to the reset address
        ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("unwind_pc", pc, 8'h13);
        end
        step();
        ret = 1'b0;
        check("underflow_pc", pc, 8'h00);
        check("underflow_flush", ir_valid, 1'b0);
        expect_range(0, 2);
        ir_ready = 1'b1;
        run_until(8'h02);
        ir_ready = 1'b0;
        check("error_sticky", stack_error, 1'b1);
`else
        // Without the stack, ret has no effect on a stalled fetch
        ret = 1'b1;
        step();
        ret = 1'b0;
        check("ret_ignored_pc", pc, 8'h32);
        check("ret_ignored_valid", ir_valid, 1'b1);
        check("ret_ignored_ir_pc", ir_pc, 8'h31);
        check("stack_error_tied", stack_error, 1'b0);
`endif

        // Reset in the middle of a stall restarts from the reset address
        reset = 1'b1;
        #1;
        check("midreset_pc", pc, 8'h00);
        check("midreset_valid", ir_valid, 1'b0);
        check("midreset_ir_pc", ir_pc, 8'h00);
        check("midreset_stack_error", stack_error, 1'b0);
        step();
        reset = 1'b0;
        expect_range(0, 2);
        ir_ready = 1'b1;
        run_until(8'h02);
        ir_ready = 1'b0;

        step();
        step();
        check("scoreboard_drained", expected_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
